multicycle_control: RTL and testbench

- Multi-cycle control FSM for the RV64 subset datapath: R-type (ADD/SUB/AND/OR), LD, SD, BEQ.
- Sequences one instruction over FETCH/DECODE/EXEC/MEM/WB against a shared single-port memory with a ready handshake.
- Drives the same control signal set as the single-cycle decoder (alu_op, memRead, memWrite, memToReg, aluSrc, regWrite) plus PC/IR write enables.
- Also counts retired instructions and traps on illegal opcodes and memory timeouts.

---
 rtl/multicycle_control_if.sv | 34 +++
 rtl/multicycle_control.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Bundle between the multi-cycle control FSM and the datapath / shared memory port.
// master = control unit side, slave = datapath and memory side.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_src;
  logic             ir_write;
  logic [1:0]       alu_op;
  logic             aluSrc;
  logic             memRead;
  logic             memWrite;
  logic             memToReg;
  logic             regWrite;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, alu_op, aluSrc, memRead, memWrite,
           memToReg, regWrite, trap, trap_cause, retired, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, alu_op, aluSrc, memRead, memWrite,
           memToReg, regWrite, trap, trap_cause, retired, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV64-subset control FSM (R-type, LD, SD, BEQ) with retire counter and traps.
// Define MULTICYCLE_ILLEGAL_NOP_EN to retire illegal opcodes as no-ops instead of trapping.
module multicycle_control #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [2:0]       state_q, state_d;
  logic [6:0]       op_q;
  logic [CNT_W-1:0] retired_q;
  logic [1:0]       cause_q, cause_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             retire;
  logic             tmo;

  logic             pc_write, pc_src, ir_write, aluSrc, memRead, memWrite;
  logic             memToReg, regWrite, trap;
  logic [1:0]       alu_op, trap_cause;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LD) || (op == OP_SD) || (op == OP_BEQ);
  endfunction

  // Last allowed wait cycle: a missing handshake here ends in TRAP.
  assign tmo = (tcnt_q == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
      cause_q   <= 2'b00;
      tcnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      tcnt_q  <= tcnt_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else if (tmo) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (is_legal(bus.opcode)) state_d = S_EXEC;
        else begin
`ifdef MULTICYCLE_ILLEGAL_NOP_EN
          state_d = S_WB;
`else
          state_d = S_TRAP;
          cause_d = 2'b01;
`endif
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R:         state_d = S_WB;
          OP_LD, OP_SD: state_d = S_MEM;
          default: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (op_q == OP_SD) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else state_d = S_WB;
        end else if (tmo) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: begin
        state_d = S_TRAP;
        cause_d = 2'b01;
      end
    endcase

    if (state_d != state_q) tcnt_d = '0;
    else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready)
      tcnt_d = tcnt_q + TW'(1);
    else tcnt_d = tcnt_q;
  end

  // Reset forces every control output low, dropping any in-flight memory request.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    alu_op     = 2'b00;
    aluSrc     = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    memToReg   = 1'b0;
    regWrite   = 1'b0;
    trap       = 1'b0;
    trap_cause = 2'b00;
    if (!rst) begin
      trap_cause = cause_q;
      case (state_q)
        S_FETCH: begin
          memRead  = 1'b1;
          ir_write = bus.mem_ready;
        end
        S_EXEC: begin
          case (op_q)
            OP_R:         alu_op = 2'b10;
            OP_LD, OP_SD: aluSrc = 1'b1;
            default: begin
              alu_op   = 2'b01;
              pc_write = 1'b1;
              pc_src   = bus.zero;
            end
          endcase
        end
        S_MEM: begin
          if (op_q == OP_SD) begin
            memWrite = 1'b1;
            pc_write = bus.mem_ready;
          end else memRead = 1'b1;
        end
        S_WB: begin
          regWrite = (op_q == OP_R) || (op_q == OP_LD);
          memToReg = (op_q == OP_LD);
          pc_write = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.ir_write   = ir_write;
  assign bus.alu_op     = alu_op;
  assign bus.aluSrc     = aluSrc;
  assign bus.memRead    = memRead;
  assign bus.memWrite   = memWrite;
  assign bus.memToReg   = memToReg;
  assign bus.regWrite   = regWrite;
  assign bus.trap       = trap;
  assign bus.trap_cause = trap_cause;
  assign bus.retired    = retired_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues hand-computed per-cycle
// expectations, the negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_ILL = 7'b1111111;

  // {pc_write, pc_src, ir_write, alu_op[1:0], aluSrc, memRead, memWrite, memToReg, regWrite, trap, trap_cause[1:0]}
  localparam logic [12:0] PCW    = 13'h1000;
  localparam logic [12:0] PCS    = 13'h0800;
  localparam logic [12:0] IRW    = 13'h0400;
  localparam logic [12:0] AF     = 13'h0200;
  localparam logic [12:0] ASUB   = 13'h0100;
  localparam logic [12:0] ASRC   = 13'h0080;
  localparam logic [12:0] MRD    = 13'h0040;
  localparam logic [12:0] MWR    = 13'h0020;
  localparam logic [12:0] M2R    = 13'h0010;
  localparam logic [12:0] RW     = 13'h0008;
  localparam logic [12:0] TRP    = 13'h0004;
  localparam logic [12:0] CA_ILL = 13'h0001;
  localparam logic [12:0] CA_TMO = 13'h0002;
  localparam logic [12:0] NONE   = 13'h0000;

  logic clk = 1'b0;
  logic rst;

  multicycle_control_if #(.CNT_W(32)) bus ();

  multicycle_control #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  logic [47:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [47:0] mon_exp, mon_act;
  string       mon_name;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {bus.state, bus.pc_write, bus.pc_src, bus.ir_write, bus.alu_op, bus.aluSrc,
                  bus.memRead, bus.memWrite, bus.memToReg, bus.regWrite, bus.trap,
                  bus.trap_cause, bus.retired};
      checks++;
      if (mon_act === mon_exp) passed++;
      else
        $display("FAIL %s: got state=%0d ctrl=%013b retired=%0d, expected state=%0d ctrl=%013b retired=%0d",
                 mon_name, mon_act[47:45], mon_act[44:32], mon_act[31:0],
                 mon_exp[47:45], mon_exp[44:32], mon_exp[31:0]);
    end
  end

  task automatic cyc(input logic r, input logic [6:0] op, input logic z, input logic rdy,
                     input logic [2:0] es, input logic [12:0] ec, input logic [31:0] er,
                     input string nm);
    rst           = r;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    exp_q.push_back({es, ec, er});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.opcode    = OP_R;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, OP_R, 0, 1, 3'd0, NONE, 0, "reset");

    // R-type, zero-wait memory: 4 cycles
    cyc(0, OP_R, 0, 1, 3'd0, MRD | IRW, 0, "r_fetch");
    cyc(0, OP_R, 0, 0, 3'd1, NONE,      0, "r_decode");
    cyc(0, OP_R, 0, 0, 3'd2, AF,        0, "r_exec");
    cyc(0, OP_R, 0, 0, 3'd4, RW | PCW,  0, "r_wb");

    // LD, data ready on the third MEM cycle: 7 cycles
    cyc(0, OP_LD, 0, 1, 3'd0, MRD | IRW,      1, "ld_fetch");
    cyc(0, OP_LD, 0, 0, 3'd1, NONE,           1, "ld_decode");
    cyc(0, OP_LD, 0, 0, 3'd2, ASRC,           1, "ld_exec");
    cyc(0, OP_LD, 0, 0, 3'd3, MRD,            1, "ld_mem_w1");
    cyc(0, OP_LD, 0, 0, 3'd3, MRD,            1, "ld_mem_w2");
    cyc(0, OP_LD, 0, 1, 3'd3, MRD,            1, "ld_mem_rdy");
    cyc(0, OP_LD, 0, 0, 3'd4, RW | PCW | M2R, 1, "ld_wb");

    // BEQ taken and not taken
    cyc(0, OP_BEQ, 1, 1, 3'd0, MRD | IRW,        2, "beq1_fetch");
    cyc(0, OP_BEQ, 1, 0, 3'd1, NONE,             2, "beq1_decode");
    cyc(0, OP_BEQ, 1, 0, 3'd2, ASUB | PCW | PCS, 2, "beq1_exec");
    cyc(0, OP_BEQ, 0, 1, 3'd0, MRD | IRW,        3, "beq0_fetch");
    cyc(0, OP_BEQ, 0, 0, 3'd1, NONE,             3, "beq0_decode");
    cyc(0, OP_BEQ, 0, 0, 3'd2, ASUB | PCW,       3, "beq0_exec");

    // R-type with one instruction-fetch wait state
    cyc(0, OP_R, 0, 0, 3'd0, MRD,       4, "rw_fetch_wait");
    cyc(0, OP_R, 0, 1, 3'd0, MRD | IRW, 4, "rw_fetch");
    cyc(0, OP_R, 0, 0, 3'd1, NONE,      4, "rw_decode");
    cyc(0, OP_R, 0, 0, 3'd2, AF,        4, "rw_exec");
    cyc(0, OP_R, 0, 0, 3'd4, RW | PCW,  4, "rw_wb");

    // SD zero-wait: 4 cycles
    cyc(0, OP_SD, 0, 1, 3'd0, MRD | IRW, 5, "sd_fetch");
    cyc(0, OP_SD, 0, 0, 3'd1, NONE,      5, "sd_decode");
    cyc(0, OP_SD, 0, 0, 3'd2, ASRC,      5, "sd_exec");
    cyc(0, OP_SD, 0, 1, 3'd3, MWR | PCW, 5, "sd_mem");

    // SD whose handshake lands in the 16th MEM cycle: no trap
    cyc(0, OP_SD, 0, 1, 3'd0, MRD | IRW, 6, "sd16_fetch");
    cyc(0, OP_SD, 0, 0, 3'd1, NONE,      6, "sd16_decode");
    cyc(0, OP_SD, 0, 0, 3'd2, ASRC,      6, "sd16_exec");
    for (int i = 0; i < 15; i++) cyc(0, OP_SD, 0, 0, 3'd3, MWR, 6, "sd16_mem_wait");
    cyc(0, OP_SD, 0, 1, 3'd3, MWR | PCW, 6, "sd16_mem_rdy");

    // SD that never completes: TRAP cause 10 exactly 16 cycles after MEM entry
    cyc(0, OP_SD, 0, 1, 3'd0, MRD | IRW, 7, "sdto_fetch");
    cyc(0, OP_SD, 0, 0, 3'd1, NONE,      7, "sdto_decode");
    cyc(0, OP_SD, 0, 0, 3'd2, ASRC,      7, "sdto_exec");
    for (int i = 0; i < 16; i++) cyc(0, OP_SD, 0, 0, 3'd3, MWR, 7, "sdto_mem_wait");
    for (int i = 0; i < 4; i++) cyc(0, OP_SD, 0, i[0], 3'd5, TRP | CA_TMO, 7, "sdto_trap");

    // Reset out of TRAP clears the counter and cause
    cyc(1, OP_R, 0, 1, 3'd5, NONE, 7, "rst_in_trap");
    cyc(0, OP_R, 0, 1, 3'd0, MRD | IRW, 0, "post_rst_fetch");
    cyc(0, OP_R, 0, 0, 3'd1, NONE,      0, "post_rst_decode");
    cyc(0, OP_R, 0, 0, 3'd2, AF,        0, "post_rst_exec");
    cyc(0, OP_R, 0, 0, 3'd4, RW | PCW,  0, "post_rst_wb");

    // Reset pulsed while an LD waits in MEM
    cyc(0, OP_LD, 0, 1, 3'd0, MRD | IRW, 1, "ldrst_fetch");
    cyc(0, OP_LD, 0, 0, 3'd1, NONE,      1, "ldrst_decode");
    cyc(0, OP_LD, 0, 0, 3'd2, ASRC,      1, "ldrst_exec");
    cyc(0, OP_LD, 0, 0, 3'd3, MRD,       1, "ldrst_mem");
    cyc(1, OP_LD, 0, 0, 3'd3, NONE,      1, "ldrst_drop");

    // Illegal opcode
    cyc(0, OP_ILL, 0, 1, 3'd0, MRD | IRW, 0, "ill_fetch");
    cyc(0, OP_ILL, 0, 0, 3'd1, NONE,      0, "ill_decode");
`ifdef MULTICYCLE_ILLEGAL_NOP_EN
    cyc(0, OP_ILL, 0, 0, 3'd4, PCW,       0, "ill_nop_retire");
    cyc(0, OP_R,   0, 1, 3'd0, MRD | IRW, 1, "ill_nop_next_fetch");
`else
    for (int i = 0; i < 20; i++) cyc(0, OP_ILL, 0, 1, 3'd5, TRP | CA_ILL, 0, "ill_trap");
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
